port_out: RTL
=============

// Module: port_out
// PURPOSE
// - Output-port arbiter and forwarder for one of the 16 outputs of the 16x16 crosspoint router.
// - Downstream of the 16 input-port stages. Each input stage requests this output after decoding
//   its 4-bit address. This block grants one requester round-robin, drives busy, and re-times
//   the granted stage's frame_n/valid_n/din onto the output pins.
// - Port wiring:
//   - input stage i request[j] -> port_out j req[i]
//   - port_out j grant[i] -> input stage i grant[j]
//   - port_out j busy -> busy_in[j] of every input stage
// PARAMETERS
// N_PORTS   16   number of input stages competing for this output
// IDX_W     4    width of winner index / round-robin pointer (clog2 N_PORTS)
// PORTS
// clock      in   1        rising-edge clock
// reset      in   1        asynchronous, active-high reset
// req        in   N_PORTS  bit i = input stage i requests this output (level, held through payload)
// frame_n_in in   N_PORTS  bit i = frame_n lane from input stage i to this output
// valid_n_in in   N_PORTS  bit i = valid_n lane from input stage i to this output
// din        in   N_PORTS  bit i = serial data lane from input stage i to this output
// grant      out  N_PORTS  one-hot grant to the winning input stage, all-zero when none
// busy       out  1        1 = output carrying a packet, 0 = free
// frameo_n   out  1        registered frame_n of winner (idle 1)
// valido_n   out  1        registered valid_n of winner (idle 1)
// dout       out  1        registered data of winner (idle 0)
// BEHAVIOUR
// - Reset (async, any cycle, incl. mid-packet) forces:
//   - state=IDLE, grant=0, busy=0
//   - frameo_n=1, valido_n=1, dout=0
//   - ptr=N_PORTS-1, so input 0 has highest priority first
// - FSM states IDLE, GRANT, XFER. All outputs are registered.
// - IDLE:
//   - busy=0, grant=0.
//   - If req!=0: winner = first set bit scanning ptr+1, ptr+2 ... with wrap mod N_PORTS.
//     Latch winner; grant=onehot(winner) from next cycle; go GRANT.
// - GRANT:
//   - busy=0 while grant held, so the input stage sees !busy && grant and enters payload.
//   - If req[winner]=1: go XFER. Otherwise (request withdrawn): grant=0, go IDLE, ptr unchanged.
// - XFER:
//   - busy=1, grant held.
//   - Each cycle, frameo_n/valido_n/dout <= frame_n_in/valid_n_in/din[winner].
//   - Forwarding latency: exactly 1 clock.
//   - When req[winner]=0: go IDLE, grant=0 and busy=0 next cycle, ptr<=winner.
//     Outputs return to idle values the cycle after.
// - Outside XFER, output pins hold idle values. Lanes of non-winners are never observed
//   (they may be X/Z).
// - Round-robin:
//   - The pointer updates only on a completed XFER.
//   - The last served input gets lowest priority next time.
//   - Wrap-around from index N_PORTS-1 to 0 is seamless.
// - New requests arriving during GRANT/XFER are ignored until IDLE. No pre-emption.
// - Back-to-back: IDLE is held at least 1 cycle between packets (busy low >= 1 cycle).
// - Single requester: re-granted each time with no starvation check needed. ptr update still applies.
// - X on req while in IDLE must not be treated as a request. The bench drives req to 0/1 only.
// TESTING
// 1. Reset: assert reset mid-XFER with winner=5 -> same cycle grant=0, busy=0, frameo_n=1,
//    valido_n=1, dout=0. Next request from input 0 wins first.
// 2. Single packet: req[3]=1 ->
//    - grant=16'h0008 after 1 clk
//    - busy=1 one clk later
//    - dout follows din[3] delayed 1 clk
//    - req[3]=0 -> grant=0, busy=0 next clk
// 3. Contention: req=16'h8011 held continuously, ptr=15 after reset -> grant order
//    16'h0001, 16'h0010, 16'h8000, 16'h0001 (wrap).
// 4. Withdrawal: req[7] pulses 1 then drops during GRANT -> back to IDLE, busy never rises.
//    A later req[2] with ptr=15 grants 16'h0004.
// 5. Late arrival: req[1] set while input 9 in XFER -> grant stays 16'h0200 until req[9] drops.
//    Then 1 IDLE cycle, then grant=16'h0002.
// 6. Isolation: toggle frame_n_in/din of non-winners randomly during XFER of winner 12 ->
//    frameo_n/dout match lane 12 only, 1-clk delayed.

Source files
------------

// File: rtl/port_out.sv
// Output-port arbiter/forwarder for one router output: round-robin grant among
// requesting input stages, busy handshake, and 1-clock re-timing of the winner's lanes.
module port_out #(
  parameter int N_PORTS = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] frame_n_in,
  input  logic [N_PORTS-1:0] valid_n_in,
  input  logic [N_PORTS-1:0] din,
  output logic [N_PORTS-1:0] grant,
  output logic               busy,
  output logic               frameo_n,
  output logic               valido_n,
  output logic               dout
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_winner;
  logic [IDX_W-1:0] idx;
  logic             any_req;

  // Scan from the farthest slot (ptr itself) toward ptr+1, so the nearest
  // requester after the last-served one is written last and wins.
  always_comb begin
    // NOTE: every variable gets a default first, otherwise the tool infers a latch.
    next_winner = ptr;
    any_req     = 1'b0;
    idx         = ptr;
    for (int k = N_PORTS; k >= 1; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        next_winner = idx;
        any_req     = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      frameo_n <= 1'b1;
      valido_n <= 1'b1;
      dout     <= 1'b0;
      ptr      <= IDX_W'(N_PORTS - 1);
      winner   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy     <= 1'b0;
          frameo_n <= 1'b1;
          valido_n <= 1'b1;
          dout     <= 1'b0;
          if (any_req) begin
            winner <= next_winner;
            grant  <= N_PORTS'(1) << next_winner;
            state  <= GRANT;
          end else begin
            grant  <= '0;
          end
        end
        GRANT: begin
          frameo_n <= 1'b1;
          valido_n <= 1'b1;
          dout     <= 1'b0;
          if (req[winner]) begin
            busy  <= 1'b1;
            state <= XFER;
          end else begin
            // Request withdrawn before payload: the pointer keeps its old value.
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        XFER: begin
          frameo_n <= frame_n_in[winner];
          valido_n <= valid_n_in[winner];
          dout     <= din[winner];
          if (!req[winner]) begin
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= winner;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
